alu_wide_seq: RTL and testbench

Multi-byte operation sequencer that drives the 8-bit combinational ALU as its initiator. It accepts a wide operand pair and an operation over a start/done handshake, then issues one byte-wide ALU command per cycle, LSB first, chaining carry through `ALU_ADDC`. It accumulates the byte results and returns the wide result with carry and zero flags. It sits between the x9 control path and the ALU, implementing 16-bit (or wider) arithmetic on the 8-bit datapath.

---
 rtl/alu_wide_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_wide_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// Multi-byte ADD/SUB/AND/OR sequencer driving an 8-bit combinational ALU, LSB first,
// plus the ALU command package and the byte ALU it is paired with.

package ALU_def;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADDC = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NEG  = 3'd6,
    ALU_PASS = 3'd7
  } ALU_CTRL;
endpackage

module alu8
  import ALU_def::*;
(
  input  ALU_CTRL    ctrl,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout,
  output logic       zero
);
  logic [8:0] sum;

  // ALU_NEG is the bitwise invert of a; SUB carry out of 1 means no borrow.
  always_comb begin
    sum = 9'd0;
    case (ctrl)
      ALU_ADD:  sum = {1'b0, a} + {1'b0, b};
      ALU_ADDC: sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      ALU_SUB:  sum = {1'b0, a} + {1'b0, ~b} + 9'd1;
      ALU_AND:  sum = {1'b0, a & b};
      ALU_OR:   sum = {1'b0, a | b};
      ALU_XOR:  sum = {1'b0, a ^ b};
      ALU_NEG:  sum = {1'b0, ~a};
      ALU_PASS: sum = {1'b0, a};
      default:  sum = 9'd0;
    endcase
  end

  assign y    = sum[7:0];
  assign cout = sum[8];
  assign zero = (sum[7:0] == 8'd0);
endmodule

module alu_wide_seq
  import ALU_def::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [8*NBYTES-1:0] opa,
  input  logic [8*NBYTES-1:0] opb,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                zero,
  output ALU_CTRL             alu_ctrl,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_cin,
  input  logic [7:0]          alu_out,
  input  logic                alu_cout,
  input  logic                alu_zero,
  output logic [1:0]          dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_NEG = 2'd1, S_EXEC = 2'd2} state_t;

  state_t          state;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [1:0]      op_q;
  logic [IW-1:0]   idx;
  logic [7:0]      nb_q;
  logic            carry_q;
  logic            zacc_q;
  logic [W-1:0]    res_acc;
  logic [W-1:0]    res_next;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            is_arith;
  logic            last_byte;

  assign dbg_state = state;
  assign a_byte    = opa_q[8*int'(idx) +: 8];
  assign b_byte    = opb_q[8*int'(idx) +: 8];
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last_byte = (idx == IW'(NBYTES - 1));

  always_comb begin
    res_next = res_acc;
    res_next[8*int'(idx) +: 8] = alu_out;
  end

  // ALU command decode depends only on registered state, never on start.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = 8'd0;
    alu_b    = 8'd0;
    alu_cin  = 1'b0;
    case (state)
      S_NEG: begin
        alu_ctrl = ALU_NEG;
        alu_a    = b_byte;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            alu_ctrl = ALU_ADDC;
            alu_a    = a_byte;
            alu_b    = b_byte;
            alu_cin  = carry_q;
          end
          OP_SUB: begin
            alu_ctrl = ALU_ADDC;
            alu_a    = a_byte;
            alu_b    = nb_q;
            alu_cin  = carry_q;
          end
          OP_AND: begin
            alu_ctrl = ALU_AND;
            alu_a    = a_byte;
            alu_b    = b_byte;
          end
          default: begin
            alu_ctrl = ALU_OR;
            alu_a    = a_byte;
            alu_b    = b_byte;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= 2'b00;
      idx       <= '0;
      nb_q      <= 8'd0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      res_acc   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opa_q   <= opa;
            opb_q   <= opb;
            op_q    <= op;
            idx     <= '0;
            zacc_q  <= 1'b1;
            carry_q <= (op == OP_SUB);
            busy    <= 1'b1;
            state   <= (op == OP_SUB) ? S_NEG : S_EXEC;
          end
        end
        S_NEG: begin
          nb_q  <= alu_out;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_acc <= res_next;
          zacc_q  <= zacc_q & alu_zero;
          carry_q <= is_arith ? alu_cout : 1'b0;
          if (last_byte) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= res_next;
            carry_out <= is_arith ? alu_cout : 1'b0;
            zero      <= zacc_q & alu_zero;
          end else begin
            idx   <= idx + IW'(1);
            state <= (op_q == OP_SUB) ? S_NEG : S_EXEC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq (NBYTES=2) paired with a real alu8 instance.

module tb_alu_wide_seq;
  import ALU_def::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  ALU_CTRL      alu_ctrl;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_out;
  logic         alu_cout;
  logic         alu_zero;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  logic       exp_cin_q[$];

  alu_wide_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  alu8 u_alu (
    .ctrl(alu_ctrl), .a(alu_a), .b(alu_b), .cin(alu_cin),
    .y(alu_out), .cout(alu_cout), .zero(alu_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; start is held across exactly one rising edge.
  // With poke set, a second start (ADD, other operands) is pulsed mid-operation.
  task automatic do_op(input string tag, input logic [1:0] op_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input logic [W-1:0] exp_r,
                       input logic exp_c, input logic exp_z, input bit poke);
    int lat;
    int n;
    int busy_cnt;
    logic c0;
    logic [8:0] s0;
    lat = (op_i == OP_SUB) ? 2 * NB : NB;
    c0  = (op_i == OP_SUB);
    s0  = {1'b0, a_i[7:0]} + {1'b0, (op_i == OP_SUB) ? ~b_i[7:0] : b_i[7:0]} + {8'd0, c0};
    exp_q.delete();
    exp_cin_q.delete();
    case (op_i)
      OP_ADD: begin
        exp_q.push_back(3'(ALU_ADDC)); exp_cin_q.push_back(1'b0);
        exp_q.push_back(3'(ALU_ADDC)); exp_cin_q.push_back(s0[8]);
      end
      OP_SUB: begin
        exp_q.push_back(3'(ALU_NEG));  exp_cin_q.push_back(1'b0);
        exp_q.push_back(3'(ALU_ADDC)); exp_cin_q.push_back(1'b1);
        exp_q.push_back(3'(ALU_NEG));  exp_cin_q.push_back(1'b0);
        exp_q.push_back(3'(ALU_ADDC)); exp_cin_q.push_back(s0[8]);
      end
      OP_AND: begin
        exp_q.push_back(3'(ALU_AND)); exp_cin_q.push_back(1'b0);
        exp_q.push_back(3'(ALU_AND)); exp_cin_q.push_back(1'b0);
      end
      default: begin
        exp_q.push_back(3'(ALU_OR)); exp_cin_q.push_back(1'b0);
        exp_q.push_back(3'(ALU_OR)); exp_cin_q.push_back(1'b0);
      end
    endcase
    start = 1'b1; op = op_i; opa = a_i; opb = b_i;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done || n > 20) break;
      if (busy) busy_cnt++;
      if (exp_q.size() > 0) begin
        check({tag, "_ctrl"}, 32'(alu_ctrl), 32'(exp_q.pop_front()));
        check({tag, "_cin"}, 32'(alu_cin), 32'(exp_cin_q.pop_front()));
      end
      if (poke && n == 2) begin
        start = 1'b1; op = OP_ADD; opa = 16'hFFFF; opb = 16'hFFFF;
      end
      if (poke && n == 3) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat + 1));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_res"}, 32'(result), 32'(exp_r));
    check({tag, "_c"}, 32'(carry_out), 32'(exp_c));
    check({tag, "_z"}, 32'(zero), 32'(exp_z));
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    rst = 1'b0;
    @(negedge clk);

    do_op("add_carry",  OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("res_hold", 32'(result), 32'h0100);
    do_op("add_wrap",   OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    do_op("sub_basic",  OP_SUB, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0, 1'b0);
    do_op("sub_borrow", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_op("sub_equal",  OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("and_bits",   OP_AND, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_op("or_bits",    OP_OR,  16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // back-to-back: OR issued in the ADD's done cycle
    do_op("b2b_add",    OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
    do_op("b2b_or",     OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    do_op("sub_poke",   OP_SUB, 16'h5000, 16'h1234, 16'h3DCC, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // reset in SUB cycle 2
    start = 1'b1; op = OP_SUB; opa = 16'h4321; opb = 16'h0101;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_res", 32'(result), 32'd0);
    check("mrst_c", 32'(carry_out), 32'd0);
    check("mrst_z", 32'(zero), 32'd0);
    check("mrst_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    check("mrst_ab", 32'({alu_a, alu_b, 7'd0, alu_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mrst_no_done", 32'(done_seen), 32'd0);
    do_op("add_after",  OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
